// File: rtl/sme_rng.sv
// -----------------------------------------------------------------------------
// sme_rng : masking-randomness source for the SME datapath.
//
// Holds RMAX independent 32-bit xorshift lanes (RMAX = SMAX + SMAX*(SMAX-1)/2)
// and presents them as the rng word array consumed by the SME ALU. The lanes
// are seeded one word per accepted beat, advance once per ALU step, and a
// reseed request rises after RESEED_INTERVAL steps.
//
// Ports:
//   g_clk       - clock
//   g_resetn    - asynchronous active-low reset
//   seed_valid  - seed word offered
//   seed_ready  - always 1 (no backpressure)
//   seed        - seed word, XORed into lane[load_idx]
//   step        - advance every lane by one xorshift step (RUN only)
//   rng_valid   - all lanes seeded, randomness usable
//   rng         - lane registers, straight from flops
//   reseed_req  - step budget exhausted, host should supply a new seed set
//   load_idx    - next lane to be loaded (visibility)
// -----------------------------------------------------------------------------
module sme_rng #(
  parameter int          XLEN            = 32,
  parameter int          SMAX            = 4,
  parameter logic [31:0] RESET_SEED      = 32'hACE1_2B3D,
  parameter logic [15:0] RESEED_INTERVAL = 16'd1024,
  localparam int         RMAX            = SMAX + (SMAX * (SMAX - 1)) / 2,
  localparam int         RM              = RMAX - 1,
  localparam int         LIW             = (RMAX > 1) ? $clog2(RMAX) : 1
) (
  input  logic                     g_clk,
  input  logic                     g_resetn,
  input  logic                     seed_valid,
  output logic                     seed_ready,
  input  logic [XLEN-1:0]          seed,
  input  logic                     step,
  output logic                     rng_valid,
  output logic [RM:0][XLEN-1:0]    rng,
  output logic                     reseed_req,
  output logic [LIW-1:0]           load_idx
);

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    LOAD     = 2'd1,
    RUN      = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [RM:0][XLEN-1:0]   lane_d;
  logic [LIW-1:0]          idx_d;
  logic [15:0]             step_cnt, cnt_d;
  logic                    req_d;

  // A zero lane would lock xorshift at zero forever, so loads are forced to 1.
  function automatic logic [XLEN-1:0] fix(input logic [XLEN-1:0] x);
    fix = (x == '0) ? XLEN'(1) : x;
  endfunction

  // 32-bit xorshift (13, 17, 5); bijective, so nonzero stays nonzero.
  function automatic logic [XLEN-1:0] xs(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] t;
    t = x;
    t = t ^ (t << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    xs = t;
  endfunction

  function automatic logic [XLEN-1:0] reset_lane(input int i);
    reset_lane = fix(XLEN'(RESET_SEED ^ (32'(i) * 32'h0101_0101)));
  endfunction

  assign seed_ready = 1'b1;
  assign rng_valid  = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    lane_d  = rng;
    idx_d   = load_idx;
    cnt_d   = step_cnt;
    req_d   = reseed_req;

    if (seed_valid) begin
      // Any accepted beat loads lane[load_idx]; in RUN load_idx is 0, so a
      // beat there starts a fresh reload and the step (if any) is dropped.
      for (int i = 0; i < RMAX; i++) begin
        if (load_idx == LIW'(i)) lane_d[i] = fix(rng[i] ^ seed);
      end
      if (load_idx == LIW'(RM)) begin
        state_d = RUN;
        idx_d   = '0;
        cnt_d   = '0;
        req_d   = 1'b0;
      end else begin
        state_d = LOAD;
        idx_d   = load_idx + LIW'(1);
      end
    end else if ((state_q == RUN) && step) begin
      for (int i = 0; i < RMAX; i++) lane_d[i] = xs(rng[i]);
      if (step_cnt != 16'hFFFF) cnt_d = step_cnt + 16'd1;
      // Sticky until the next complete reload.
      if (cnt_d == RESEED_INTERVAL) req_d = 1'b1;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q    <= UNSEEDED;
      load_idx   <= '0;
      step_cnt   <= '0;
      reseed_req <= 1'b0;
      for (int i = 0; i < RMAX; i++) rng[i] <= reset_lane(i);
    end else begin
      state_q    <= state_d;
      load_idx   <= idx_d;
      step_cnt   <= cnt_d;
      reseed_req <= req_d;
      rng        <= lane_d;
    end
  end

endmodule

// File: doc/sme_rng.md
Name: sme_rng

Overview:
- Masking-randomness source for the SME datapath.
- Holds RMAX independent 32-bit xorshift lanes and presents them as the rng[RM:0] word array consumed directly by the SME ALU (mask, remask, DOM-AND and adder guard shares).
- Lanes are seeded over a valid/ready seed interface and advanced once per ALU step.
- Raises a reseed request after a programmable number of steps.

Parameters:
- XLEN, 32: lane width; only 32 is supported because the xorshift constants are fixed.
- SMAX, 4: maximum hardware shares. RMAX = SMAX + SMAX*(SMAX-1)/2 lanes (10 at default); RM = RMAX-1.
- RESET_SEED, 32'hACE1_2B3D: lane 0 reset value. Must be nonzero.
- RESEED_INTERVAL, 16'd1024: number of RUN steps after which reseed_req asserts. Must be ≥1.

Ports:
- g_clk, in, 1: global clock. Single clock domain.
- g_resetn, in, 1: asynchronous active-low reset.
- seed_valid, in, 1: seed word offered.
- seed_ready, out, 1: seed word accepted when seed_valid && seed_ready.
- seed, in, 32: seed word.
- step, in, 1: advance all lanes. Driven by the ALU new-instruction strobe.
- rng_valid, out, 1: lanes are fully seeded and usable.
- rng, out, XLEN x RMAX: lane registers, driven directly from flops.
- reseed_req, out, 1: step budget exhausted; the host should supply a fresh seed set.
- load_idx, out, ceil(log2(RMAX)): next lane index to be loaded. Debug/visibility.

Behaviour:
- Reset (async, g_resetn=0):
  - Lane i = RESET_SEED ^ (i * 32'h0101_0101), truncated to 32 bits. Any lane that would be 0 becomes 32'h1.
  - state=UNSEEDED, load_idx=0, step_cnt=0.
  - rng_valid=0, reseed_req=0, seed_ready=1.
- fix(x): returns 32'h1 if x==0, else x.
- xs(x): x^=x<<13; x^=x>>17; x^=x<<5, all mod 2^32. Example: xs(1)=32'h0004_2021.
- seed_ready is 1 in every state. No backpressure.
- Seed beat (accepted): next cycle lane[load_idx] <= fix(lane[load_idx] ^ seed), and load_idx increments.
- States:
  - UNSEEDED: first seed beat goes to LOAD and loads lane 0. step is ignored.
  - LOAD: each beat loads one lane. The beat that loads lane RM moves to RUN, with load_idx=0, step_cnt=0 and reseed_req=0. rng_valid=0 throughout. step is ignored and lanes not being loaded hold.
  - RUN: rng_valid=1.
    - step=1 with no seed beat: every lane <= xs(lane); step_cnt saturating +1. reseed_req sets on the cycle step_cnt reaches RESEED_INTERVAL and stays high.
    - Seed beat (with or without step): reseed. Lane 0 is loaded, step is ignored that cycle, state goes to LOAD with load_idx=1. rng_valid falls the next cycle.
- Latency:
  - Lanes update one cycle after the step or seed edge.
  - rng_valid rises the cycle after the beat that loads lane RM.
  - A full seed set takes exactly RMAX accepted beats, which need not be consecutive.
- xs never maps nonzero to zero, so RUN lanes stay nonzero.
- reseed_req clears only on entry to RUN after a complete reload.
- Reset asserted mid-LOAD or mid-RUN: immediate return to reset values. No partial seed is retained.
- Gaps (seed_valid=0) during LOAD hold all state.
- RMAX=1 (SMAX=1): the first beat goes straight to RUN.

Test Plan:
- Reset then 10 beats of seed=0 (SMAX=4):
  - rng_valid=0 during beats 1-9, rng_valid=1 the cycle after beat 10.
  - lane0=32'hACE1_2B3D and lane1=32'hADE0_2A3C (unchanged reset values).
- Reset, beat 1 seed=32'hACE1_2B3C (XOR gives 1), 9 zero beats, one step:
  - lane0=32'h0004_2021.
  - All other lanes equal xs of their reset values.
- Zero-forcing:
  - Beat 1 seed=32'hACE1_2B3D -> lane0=32'h1.
  - After completing the load and one step -> lane0=32'h0004_2021.
- step pulses in UNSEEDED and mid-LOAD -> no lane change, step_cnt stays 0.
- Reseed budget (RESEED_INTERVAL=3):
  - 2 steps -> reseed_req=0; 3rd step -> reseed_req=1.
  - 4th step -> lanes advance, reseed_req stays 1.
  - 10-beat reload -> reseed_req=0 in RUN.
- Step coinciding with a seed beat in RUN: lane0 loaded and not stepped, lanes 1-9 unchanged, rng_valid=0 next cycle, load_idx=1.
- Async reset after 5 beats: outputs return to reset values immediately without a clock edge. A full 10-beat set is then required for rng_valid.
